// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC3 memory responder.
// Both channel FSMs and the top level import this package.
package lc3_mem_pkg;

    typedef enum logic {
        RSP_IDLE = 1'b0,
        RSP_WAIT = 1'b1
    } rsp_state_t;

    localparam int LC3_WORD_W = 16;
    localparam int LC3_WAIT_W = 3;
    localparam logic [15:0] LC3_BASE_ADDR = 16'h3000;
    localparam int MAX_WAIT = (1 << LC3_WAIT_W) - 1;

endpackage

// File: rtl/lc3_mem_wait_fsm.sv
// One request/complete channel with a programmable wait count.
// A request aborts if it drops or its tag changes while waiting.
module lc3_mem_wait_fsm
    import lc3_mem_pkg::*;
#(
    parameter int TAG_W  = 16,
    parameter int WAIT_W = LC3_WAIT_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic [TAG_W-1:0]  tag,
    input  logic [WAIT_W-1:0] wait_cycles,
    output logic              complete
);

    rsp_state_t        state;
    rsp_state_t        state_nxt;
    logic [WAIT_W-1:0] cnt;
    logic [WAIT_W-1:0] cnt_nxt;
    logic [TAG_W-1:0]  tag_q;
    logic [TAG_W-1:0]  tag_nxt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= RSP_IDLE;
            cnt   <= '0;
            tag_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            tag_q <= tag_nxt;
        end
    end

    // The counter holds the remaining wait cycles; complete fires when it hits zero.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tag_nxt   = tag_q;
        complete  = 1'b0;
        case (state)
            RSP_IDLE: begin
                if (req) begin
                    if (wait_cycles == '0) begin
                        complete = 1'b1;
                    end else begin
                        state_nxt = RSP_WAIT;
                        cnt_nxt   = wait_cycles - WAIT_W'(1);
                        tag_nxt   = tag;
                    end
                end
            end
            RSP_WAIT: begin
                if (!req || (tag != tag_q)) begin
                    state_nxt = RSP_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == '0) begin
                    complete  = 1'b1;
                    state_nxt = RSP_IDLE;
                end else begin
                    cnt_nxt = cnt - WAIT_W'(1);
                end
            end
            default: begin
                state_nxt = RSP_IDLE;
                cnt_nxt   = '0;
            end
        endcase
        // Zero-wait completes are combinational, so reset must mask them directly.
        if (!reset) begin
            complete = 1'b0;
        end
    end

endmodule

// File: rtl/lc3_mem_responder.sv
// Unified word array answering LC3 fetch and data ports with programmable wait states.
// Reads are asynchronous; writes and preloads land on the rising clock edge.
module lc3_mem_responder
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = LC3_WORD_W,
    parameter int WAIT_W = LC3_WAIT_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic              instrmem_rd,
    output logic [DATA_W-1:0] Instr_dout,
    output logic              complete_instr,
    input  logic              data_req,
    input  logic [ADDR_W-1:0] Data_addr,
    input  logic              Data_rd,
    input  logic [DATA_W-1:0] Data_din,
    output logic [DATA_W-1:0] Data_dout,
    output logic              complete_data,
    input  logic [WAIT_W-1:0] instr_wait,
    input  logic [WAIT_W-1:0] data_wait,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data
);

    localparam int DTAG_W = ADDR_W + 1 + DATA_W;

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DTAG_W-1:0] data_tag;

    assign data_tag = {Data_addr, Data_rd, Data_din};

    lc3_mem_wait_fsm #(
        .TAG_W  (ADDR_W),
        .WAIT_W (WAIT_W)
    ) u_fetch (
        .clock       (clock),
        .reset       (reset),
        .req         (instrmem_rd),
        .tag         (pc),
        .wait_cycles (instr_wait),
        .complete    (complete_instr)
    );

    lc3_mem_wait_fsm #(
        .TAG_W  (DTAG_W),
        .WAIT_W (WAIT_W)
    ) u_data (
        .clock       (clock),
        .reset       (reset),
        .req         (data_req),
        .tag         (data_tag),
        .wait_cycles (data_wait),
        .complete    (complete_data)
    );

    // Preload takes priority; a colliding data write is dropped but still completes.
    always_ff @(posedge clock) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end else if (complete_data && !Data_rd) begin
            mem[Data_addr] <= Data_din;
        end
    end

    assign Instr_dout = mem[pc];
    assign Data_dout  = mem[Data_addr];

endmodule

// File: doc/lc3_mem_responder.md
Name: lc3_mem_responder

Overview:
- Synthesizable memory-side responder for the LC3 core's instruction and data ports.
- Answers fetches (pc/instrmem_rd) and data accesses (Data_addr/Data_rd/Data_din) with complete_instr/complete_data after a runtime-programmable number of wait states.
- Sits between the core and a unified von Neumann word array. Lets the bench and integration exercise stall paths with fetch latency 0..7 and data latency 0..7.

Parameters:
- ADDR_W, 16, address width; the array holds 2^ADDR_W words.
- DATA_W, 16, word width.
- WAIT_W, 3, wait-count width; maximum wait is 2^WAIT_W-1.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; clears FSMs and counters.
- pc  in  ADDR_W  fetch address.
- instrmem_rd  in  1  fetch request, held until complete_instr.
- Instr_dout  out  DATA_W  fetched word.
- complete_instr  out  1  fetch done, 1-cycle pulse per request.
- data_req  in  1  data access valid; integration glue drives it from the controller memory state.
- Data_addr  in  ADDR_W  data address.
- Data_rd  in  1  1 = read, 0 = write.
- Data_din  in  DATA_W  write data.
- Data_dout  out  DATA_W  read data.
- complete_data  out  1  data access done, 1-cycle pulse.
- instr_wait  in  WAIT_W  fetch wait states, sampled at request start.
- data_wait  in  WAIT_W  data wait states, sampled at request start.
- load_en  in  1  backdoor preload strobe.
- load_addr  in  ADDR_W  preload address.
- load_data  in  DATA_W  preload word.

Behaviour:
- Reset value of every output: complete_instr=0 and complete_data=0. Instr_dout and Data_dout are combinational array reads and are not reset.
- Array contents survive reset.
- Reads are asynchronous: Instr_dout=mem[pc] and Data_dout=mem[Data_addr] at all times.
- Two independent copies of a single channel FSM: fetch (req=instrmem_rd, addr=pc) and data (req=data_req, addr={Data_addr,Data_rd,Data_din}).
- FSM states: IDLE and WAIT, plus counter cnt.
- In IDLE with req=1 and wait=0: complete is asserted combinationally in the same cycle; the FSM stays in IDLE.
- In IDLE with req=1 and wait=N>0: the FSM latches addr, loads cnt=N-1 and goes to WAIT. complete stays 0 in the request cycle.
- In WAIT with cnt>0: cnt decrements each cycle.
- In WAIT with cnt=0: complete=1 for exactly that cycle, then the FSM returns to IDLE.
- Latency: complete rises exactly N cycles after the first request cycle.
- Back-to-back: if req is still 1 in the IDLE cycle after completion, a new request starts and re-samples the wait input. Zero-wait requests complete every cycle that req=1.
- Abort: if req drops or addr differs from the latched value while in WAIT, the FSM goes to IDLE on that edge with no complete. A new request restarts from IDLE on the following cycle.
- Write: data complete with Data_rd=0 writes mem[Data_addr] <= Data_din on that clock edge.
- A fetch from the same address in that cycle returns the old word. The new word is visible from the next cycle.
- Preload: load_en=1 writes mem[load_addr] <= load_data.
- Preload wins over a same-cycle data write to any address; the data write is dropped and complete_data is still pulsed.
- Preload is legal at any time but intended during reset.
- Fetch and data channels never block each other; both completes may pulse in the same cycle.
- Reset asserted mid-WAIT: both FSMs go to IDLE and cnt=0 immediately (asynchronous). Completes drop in the same delta; no partial write occurs.
- Address arithmetic: no wrap logic needed; the full ADDR_W index covers the whole array.

Decomposition:
- Shared package lc3_mem_pkg:
  - rsp_state_t enum {RSP_IDLE, RSP_WAIT}.
  - LC3_WORD_W=16.
  - LC3_BASE_ADDR=16'h3000.
  - MAX_WAIT derived from WAIT_W.
- Sub-module lc3_mem_wait_fsm: one channel FSM, counter and address-latch/abort compare. Instantiated twice, once for fetch and once for data.
- Top level holds the array, write/preload muxing and the read paths.

Test Plan:
- Zero-wait fetch: preload mem[0x3000]=0x1261; instr_wait=0, pc=0x3000, instrmem_rd=1 -> complete_instr=1 in the same cycle, Instr_dout=0x1261, pulses every cycle while held.
- Fetch wait 4: request at cycle t -> complete_instr=0 for t..t+3, 1 at t+4 only, 0 at t+5 (restart), next pulse at t+9.
- Fetch abort: instr_wait=3, pc=0x3000 for 1 cycle, then 0x3005 (mem=0xABCD) -> no pulse for 0x3000; single pulse 4 cycles after the change with Instr_dout=0xABCD.
- Data write then read: data_wait=2, data_req=1, Data_rd=0, Data_addr=0x4000, Data_din=0xBEEF -> complete_data at t+2; then data_wait=0 read of 0x4000 -> same-cycle complete_data, Data_dout=0xBEEF.
- Concurrent channels: instr_wait=1 and data_wait=3, both requested at t -> complete_instr at t+1, complete_data at t+3; load_en to 0x5000 collides with a data write to 0x5000 -> load_data retained.
- Reset mid-wait: data_wait=5, drive reset=0 at t+2 -> complete_data stays 0 and the write never occurs; mem[0x3000] preload is still readable after reset release.
